// File: rtl/ssp_uart_pkg.sv
// Shared constants, FSM state type and helpers for the SSP_UART access controller.
// Optional IRQ status polling in the top is enabled by SSP_IRQ_POLL_EN.
package ssp_uart_pkg;

  localparam int SSP_RA_W     = 3;
  localparam int SSP_DW       = 12;
  localparam int FRAME_BITS   = 16;
  localparam int EN_FIRST_BIT = 4;

  localparam logic [SSP_RA_W-1:0] STAT_RA = 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Reads drive zero on SSP_DI so the slave never sees stale write data.
  function automatic logic [SSP_DW-1:0] frame_di(input logic wnr, input logic [SSP_DW-1:0] wd);
    return wnr ? wd : '0;
  endfunction

endpackage

// File: rtl/ssp_rr_arb.sv
// Combinational round-robin arbiter: lowest offset from ptr_i with a pending request wins.
// Produces a one-hot grant, the winner's index and a valid flag.
module ssp_rr_arb #(
  parameter int NREQ = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  logic [IW-1:0]   cand [NREQ];
  logic [NREQ-1:0] hit;

  // cand[gi] is the requester gi positions after the pointer, wrapped at NREQ.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum       = {1'b0, ptr_i} + (IW+1)'(gi);
    assign cand[gi]  = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
    assign hit[gi]   = req_i[cand[gi]];
  end

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid_o && hit[k]) begin
        valid_o = 1'b1;
        idx_o   = cand[k];
      end
    end
    if (valid_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/ssp_uart_access_ctrl.sv
// Multi-requester SSP master: arbitrates client register accesses and runs one SSP frame each.
// Define SSP_IRQ_POLL_EN to add automatic status reads on IRQ (irq_stat / irq_stat_vld).
module ssp_uart_access_ctrl
  import ssp_uart_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int SCK_DIV = 2,
  parameter int GAP_CYC = 2
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*SSP_RA_W-1:0] req_ra,
  input  logic [NREQ-1:0]          req_wnr,
  input  logic [NREQ*SSP_DW-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [SSP_DW-1:0]        rdata,
  output logic                     busy,
  output logic                     SSP_SSEL,
  output logic                     SSP_SCK,
  output logic [SSP_RA_W-1:0]      SSP_RA,
  output logic                     SSP_WnR,
  output logic                     SSP_En,
  output logic                     SSP_EOC,
  output logic [SSP_DW-1:0]        SSP_DI,
  input  logic [SSP_DW-1:0]        SSP_DO,
  input  logic                     IRQ
`ifdef SSP_IRQ_POLL_EN
  ,
  output logic [SSP_DW-1:0]        irq_stat,
  output logic                     irq_stat_vld
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(2*SCK_DIV);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int BW = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(2*SCK_DIV-1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(SCK_DIV);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS-1);
  localparam logic [BW-1:0] BIT_EN   = BW'(EN_FIRST_BIT);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ-1);

  logic [SSP_RA_W-1:0] ra_arr [NREQ];
  logic [SSP_DW-1:0]   wd_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fields
    assign ra_arr[gi] = req_ra[gi*SSP_RA_W +: SSP_RA_W];
    assign wd_arr[gi] = req_wdata[gi*SSP_DW +: SSP_DW];
  end

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [SSP_DW-1:0]   rdata_q, rdata_d;
  logic [SSP_RA_W-1:0] ra_q, ra_d;
  logic                wnr_q, wnr_d;
  logic [SSP_DW-1:0]   di_q, di_d;
  logic                ssel_q, ssel_d;
  logic                sck_q, sck_d;
  logic                en_q, en_d;
  logic                eoc_q, eoc_d;
  logic                start_poll;
  logic                poll_active;

  ssp_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    ra_d    = ra_q;
    wnr_d   = wnr_q;
    di_d    = di_q;

    case (state_q)
      ST_IDLE: begin
        // A pending status poll pre-empts clients and leaves the RR pointer alone.
        if (start_poll) begin
          state_d = ST_SETUP;
          ra_d    = STAT_RA;
          wnr_d   = 1'b0;
          di_d    = '0;
        end else if (arb_valid) begin
          state_d = ST_SETUP;
          gnt_d   = arb_grant;
          ptr_d   = (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
          ra_d    = ra_arr[arb_idx];
          wnr_d   = req_wnr[arb_idx];
          di_d    = frame_di(req_wnr[arb_idx], wd_arr[arb_idx]);
        end
      end
      ST_SETUP: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) state_d = ST_HOLD;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_GAP;
        gap_d   = '0;
        gnt_d   = '0;
        if (!poll_active) begin
          done_d = gnt_q;
          if (!wnr_q) rdata_d = SSP_DO;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin levels are registered from the next state so they change in step with it.
    ssel_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
    sck_d  = (state_d == ST_SHIFT) && (cnt_d >= CNT_HIGH);
    en_d   = (state_d == ST_SHIFT) && (bit_d >= BIT_EN);
    eoc_d  = (state_d == ST_SHIFT) && (bit_d == BIT_LAST);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      ra_q    <= '0;
      wnr_q   <= 1'b0;
      di_q    <= '0;
      ssel_q  <= 1'b0;
      sck_q   <= 1'b0;
      en_q    <= 1'b0;
      eoc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      ra_q    <= ra_d;
      wnr_q   <= wnr_d;
      di_q    <= di_d;
      ssel_q  <= ssel_d;
      sck_q   <= sck_d;
      en_q    <= en_d;
      eoc_q   <= eoc_d;
    end
  end

`ifdef SSP_IRQ_POLL_EN
  logic              poll_q, poll_d;
  logic              armed_q, armed_d;
  logic              irq_vld_q, irq_vld_d;
  logic [SSP_DW-1:0] irq_stat_q, irq_stat_d;

  assign start_poll  = IRQ && armed_q;
  assign poll_active = poll_q;

  // One poll per IRQ assertion: re-armed only once IRQ has been observed low.
  always_comb begin
    poll_d     = poll_q;
    armed_d    = armed_q;
    irq_stat_d = irq_stat_q;
    irq_vld_d  = 1'b0;
    if (!IRQ) armed_d = 1'b1;
    if (state_q == ST_IDLE && start_poll) begin
      poll_d  = 1'b1;
      armed_d = 1'b0;
    end
    if (state_q == ST_HOLD && poll_q) begin
      poll_d     = 1'b0;
      irq_stat_d = SSP_DO;
      irq_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      poll_q     <= 1'b0;
      armed_q    <= 1'b1;
      irq_vld_q  <= 1'b0;
      irq_stat_q <= '0;
    end else begin
      poll_q     <= poll_d;
      armed_q    <= armed_d;
      irq_vld_q  <= irq_vld_d;
      irq_stat_q <= irq_stat_d;
    end
  end

  assign irq_stat     = irq_stat_q;
  assign irq_stat_vld = irq_vld_q;
`else
  logic unused_irq;
  assign unused_irq  = IRQ;
  assign start_poll  = 1'b0;
  assign poll_active = 1'b0;
`endif

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != ST_IDLE);
  assign SSP_SSEL = ssel_q;
  assign SSP_SCK  = sck_q;
  assign SSP_RA   = ra_q;
  assign SSP_WnR  = wnr_q;
  assign SSP_En   = en_q;
  assign SSP_EOC  = eoc_q;
  assign SSP_DI   = di_q;

endmodule

// File: tb/tb_ssp_uart_access_ctrl.sv
// Scoreboard bench for ssp_uart_access_ctrl: stimulus pushes expected frames, a negedge monitor checks them.
// Build with SSP_IRQ_POLL_EN defined to also exercise the IRQ status poll.
module tb_ssp_uart_access_ctrl;

  localparam int NREQ      = 2;
  localparam int SCK_DIV   = 2;
  localparam int GAP_CYC   = 2;
  localparam int FRAME_LAT = 1 + 1 + 32*SCK_DIV + 1;
  localparam int GNT_LAT   = FRAME_LAT - 1;

  logic            clk = 1'b0;
  logic            Rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ*3-1:0]  req_ra;
  logic [NREQ-1:0] req_wnr;
  logic [NREQ*12-1:0] req_wdata;
  logic [NREQ-1:0] gnt, done;
  logic [11:0]     rdata;
  logic            busy, SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC, IRQ;
  logic [2:0]      SSP_RA;
  logic [11:0]     SSP_DI, SSP_DO;
`ifdef SSP_IRQ_POLL_EN
  logic [11:0]     irq_stat;
  logic            irq_stat_vld;
`endif

  always #5 clk = ~clk;

  ssp_uart_access_ctrl #(.NREQ(NREQ), .SCK_DIV(SCK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .Clk(clk), .Rst_n(Rst_n), .req(req), .req_ra(req_ra), .req_wnr(req_wnr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .SSP_SSEL(SSP_SSEL), .SSP_SCK(SSP_SCK), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR),
    .SSP_En(SSP_En), .SSP_EOC(SSP_EOC), .SSP_DI(SSP_DI), .SSP_DO(SSP_DO), .IRQ(IRQ)
`ifdef SSP_IRQ_POLL_EN
    , .irq_stat(irq_stat), .irq_stat_vld(irq_stat_vld)
`endif
  );

  typedef struct {
    int         idx;
    logic       wnr;
    logic [2:0] ra;
    logic [11:0] di;
    logic [11:0] rd;
    int         gap;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          frame_cnt = 0;
  int          poll_cnt = 0;
  logic [11:0] model_rdata = '0;
  logic [11:0] exp_irq_stat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=timeout expected=event (t=%0t)", name, $time);
  endtask

  function automatic void push_exp(input int idx, input logic wnr, input logic [2:0] ra,
                                   input logic [11:0] wd, input logic [11:0] dov, input int gap);
    exp_t e;
    e.idx = idx;
    e.wnr = wnr;
    e.ra  = ra;
    e.di  = wnr ? wd : 12'h000;
    e.rd  = wnr ? model_rdata : dov;
    e.gap = gap;
    model_rdata = e.rd;
    sbq.push_back(e);
  endfunction

  task automatic set_fields(input int i, input logic [2:0] ra, input logic wnr, input logic [11:0] wd);
    req_ra[3*i +: 3]     = ra;
    req_wnr[i]           = wnr;
    req_wdata[12*i +: 12] = wd;
  endtask

  task automatic wait_done(input int idx, input int budget, output int n);
    for (n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (done[idx]) break;
    end
    if (n > budget) timeout($sformatf("wait_done%0d", idx));
  endtask

  task automatic wait_gnt(input int idx, input int budget);
    int n;
    for (n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (gnt[idx]) break;
    end
    if (n > budget) timeout($sformatf("wait_gnt%0d", idx));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},  gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ssel"}, SSP_SSEL, 0);
    chk({tag, "_sck"},  SSP_SCK, 0);
    chk({tag, "_ra"},   SSP_RA, 0);
    chk({tag, "_wnr"},  SSP_WnR, 0);
    chk({tag, "_en"},   SSP_En, 0);
    chk({tag, "_eoc"},  SSP_EOC, 0);
    chk({tag, "_di"},   SSP_DI, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: collects per-frame pin statistics and compares at each done (or status poll).
  initial begin
    logic        ssel_prev, sck_prev, gnt_any_prev, unstable;
    logic [2:0]  cap_ra;
    logic        cap_wnr;
    logic [11:0] cap_di;
    int          sck_cnt, en_cnt, eoc_cnt, low_cnt, last_gap, gnt_cyc;
    exp_t        e;
    ssel_prev = 0; sck_prev = 0; gnt_any_prev = 0; unstable = 0;
    cap_ra = 0; cap_wnr = 0; cap_di = 0;
    sck_cnt = 0; en_cnt = 0; eoc_cnt = 0; low_cnt = 0; last_gap = 0; gnt_cyc = 0;
    forever begin
      @(negedge clk);
      if (SSP_SSEL && !ssel_prev) begin
        cap_ra = SSP_RA; cap_wnr = SSP_WnR; cap_di = SSP_DI;
        sck_cnt = 0; en_cnt = 0; eoc_cnt = 0; unstable = 0;
        last_gap = low_cnt; low_cnt = 0;
        frame_cnt++;
      end
      if (SSP_SSEL) begin
        if (SSP_SCK && !sck_prev) sck_cnt++;
        if (SSP_En) en_cnt++;
        if (SSP_EOC) eoc_cnt++;
        if (SSP_RA !== cap_ra || SSP_WnR !== cap_wnr || SSP_DI !== cap_di) unstable = 1;
      end else begin
        low_cnt++;
      end
      if ((|gnt) && !gnt_any_prev) gnt_cyc = cyc;
      if (|done) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got=%b expected=none (t=%0t)", done, $time);
        end else begin
          e = sbq.pop_front();
          chk("done_vec", done, 1 << e.idx);
          chk("rdata", rdata, e.rd);
          chk("frame_ra", cap_ra, e.ra);
          chk("frame_wnr", cap_wnr, e.wnr);
          chk("frame_di", cap_di, e.di);
          chk("frame_stable", unstable, 0);
          chk("sck_pulses", sck_cnt, 16);
          chk("en_cycles", en_cnt, 12*2*SCK_DIV);
          chk("eoc_cycles", eoc_cnt, 2*SCK_DIV);
          chk("gnt_to_done", cyc - gnt_cyc, GNT_LAT);
          chk("gnt_cleared", gnt, 0);
          if (e.gap > 0) chk("ssel_gap", last_gap, e.gap);
        end
      end
`ifdef SSP_IRQ_POLL_EN
      if (irq_stat_vld) begin
        poll_cnt++;
        chk("irq_stat", irq_stat, exp_irq_stat);
        chk("poll_ra", cap_ra, 0);
        chk("poll_wnr", cap_wnr, 0);
        chk("poll_di", cap_di, 0);
        chk("poll_sck", sck_cnt, 16);
        chk("poll_no_done", done, 0);
      end
`endif
      ssel_prev = SSP_SSEL;
      sck_prev = SSP_SCK;
      gnt_any_prev = |gnt;
    end
  end

  initial begin
    int n, dcnt, f0;
    Rst_n = 0; req = '0; req_ra = '0; req_wnr = '0; req_wdata = '0; SSP_DO = '0; IRQ = 0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) Rst_n = 1;
    repeat (2) @(negedge clk);

    // 1: single write, req->done latency
    set_fields(0, 3'd1, 1'b1, 12'hA5C);
    push_exp(0, 1'b1, 3'd1, 12'hA5C, 12'h000, 0);
    req[0] = 1'b1;
    wait_done(0, 200, n);
    chk("t1_latency", n, FRAME_LAT);
    req[0] = 1'b0;
    repeat (5) @(negedge clk);

    // 2: read from requester 1
    SSP_DO = 12'h3F0;
    set_fields(1, 3'd2, 1'b0, 12'hFFF);
    push_exp(1, 1'b0, 3'd2, 12'hFFF, 12'h3F0, 0);
    req[1] = 1'b1;
    wait_done(1, 200, n);
    chk("t2_latency", n, FRAME_LAT);
    req[1] = 1'b0;
    repeat (5) @(negedge clk);

    // 3: persistent contention, grants alternate 0,1,0,1
    SSP_DO = 12'h0C3;
    set_fields(0, 3'd3, 1'b1, 12'h111);
    set_fields(1, 3'd4, 1'b0, 12'h222);
    push_exp(0, 1'b1, 3'd3, 12'h111, 12'h0C3, 0);
    push_exp(1, 1'b0, 3'd4, 12'h222, 12'h0C3, GAP_CYC + 1);
    push_exp(0, 1'b1, 3'd3, 12'h111, 12'h0C3, GAP_CYC + 1);
    push_exp(1, 1'b0, 3'd4, 12'h222, 12'h0C3, GAP_CYC + 1);
    req = 2'b11;
    dcnt = 0;
    for (n = 0; n < 600 && dcnt < 4; n++) begin
      @(posedge clk); #1;
      if (|done) dcnt++;
    end
    if (dcnt < 4) timeout("t3_frames");
    req = '0;
    repeat (5) @(negedge clk);

    // 4: withdraw before grant -> no frame; drop after grant -> frame completes
    f0 = frame_cnt;
    SSP_DO = 12'h123;
    set_fields(1, 3'd5, 1'b0, 12'h000);
    push_exp(1, 1'b0, 3'd5, 12'h000, 12'h123, 0);
    req[1] = 1'b1;
    wait_gnt(1, 20);
    @(negedge clk);
    set_fields(0, 3'd6, 1'b1, 12'h777);
    req[0] = 1'b1;
    repeat (10) @(negedge clk);
    req[0] = 1'b0;
    wait_done(1, 200, n);
    req[1] = 1'b0;
    repeat (100) @(negedge clk);
    chk("t4_no_withdrawn_frame", frame_cnt, f0 + 1);
    chk("t4_idle", busy, 0);
    push_exp(0, 1'b1, 3'd6, 12'h777, 12'h123, 0);
    req[0] = 1'b1;
    wait_gnt(0, 20);
    req[0] = 1'b0;
    wait_done(0, 200, n);
    repeat (5) @(negedge clk);

    // 5: reset during SHIFT bit 7 aborts the frame
    set_fields(0, 3'd2, 1'b1, 12'h2B4);
    req[0] = 1'b1;
    wait_gnt(0, 20);
    repeat (30) @(posedge clk);
    @(negedge clk) Rst_n = 0;
    @(posedge clk);
    #1 check_all_zero("midreset");
    model_rdata = '0;
    repeat (2) @(negedge clk);
    push_exp(0, 1'b1, 3'd2, 12'h2B4, 12'h000, 0);
    Rst_n = 1;
    wait_done(0, 200, n);
    chk("t5_reserve_latency", n, FRAME_LAT);
    req[0] = 1'b0;
    repeat (5) @(negedge clk);

`ifdef SSP_IRQ_POLL_EN
    // 6: IRQ status poll wins over a pending request, once per IRQ assertion
    SSP_DO = 12'h5A5;
    exp_irq_stat = 12'h5A5;
    set_fields(0, 3'd7, 1'b1, 12'h0F0);
    push_exp(0, 1'b1, 3'd7, 12'h0F0, 12'h5A5, 0);
    IRQ = 1'b1;
    req[0] = 1'b1;
    wait_done(0, 400, n);
    chk("t6_poll_first", poll_cnt, 1);
    req[0] = 1'b0;
    repeat (150) @(negedge clk);
    chk("t6_single_poll", poll_cnt, 1);
    IRQ = 1'b0;
    repeat (5) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=hang expected=finish");
    $fatal(1, "bench time limit");
  end

endmodule
